// File: rtl/alu_executor.sv
// -----------------------------------------------------------------------------
// alu_executor
// Executes one fetched 6502-style "cc=01" ALU instruction per request:
// ORA/AND/EOR/ADC/STA/LDA/CMP/SBC with immediate or memory operand.
// Optional decimal (BCD) arithmetic is compiled in with `define DECIMAL_MODE_EN.
//
// Ports
//   phi1              clock, all state changes on its rising edge
//   reset_n           synchronous active-low reset
//   instruction_ready fetcher flag; a rising edge in IDLE captures a request
//   opcode/addr/imm   fetched opcode, effective address, immediate operand
//   d_flag            decimal flag from the status owner (mirrored in status)
//   mem_rdata         read data, valid the cycle after mem_rd
//   mem_addr/mem_wdata/mem_rd/mem_wr  single-cycle memory request
//   acc               accumulator
//   status            {N,V,1,0,D,0,Z,C}
//   instruction_done  one-cycle completion pulse
//   busy              FSM not idle
//   illegal           flagged together with instruction_done for bad opcodes
// -----------------------------------------------------------------------------
module alu_executor #(
   parameter int unsigned REG_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  phi1,
   input  logic                  reset_n,
   input  logic                  instruction_ready,
   input  logic [7:0]            opcode,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [REG_WIDTH-1:0]  imm,
   input  logic                  d_flag,
   input  logic [REG_WIDTH-1:0]  mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_wdata,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [REG_WIDTH-1:0]  acc,
   output logic [7:0]            status,
   output logic                  instruction_done,
   output logic                  busy,
   output logic                  illegal
);

   localparam int unsigned MSB = REG_WIDTH - 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      EXEC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Operand/result extended by one bit to carry C out of the MSB
   typedef logic [REG_WIDTH:0] ext_t;

   localparam logic [2:0] OP_ORA = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_EOR = 3'b010;
   localparam logic [2:0] OP_ADC = 3'b011;
   localparam logic [2:0] OP_STA = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;
   localparam logic [2:0] OP_SBC = 3'b111;

   state_t                 state_q, state_d;
   logic                   rdy_q;
   logic [2:0]             aaa_q, aaa_d;
   logic [REG_WIDTH-1:0]   imm_q, imm_d;
   logic                   is_imm_q, is_imm_d;
   logic                   ill_q, ill_d;
   logic [REG_WIDTH-1:0]   acc_q, acc_d;
   logic                   n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [REG_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                   mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
   logic                   done_q, done_d, illegal_q, illegal_d;

   logic                   capture_c;
   logic [REG_WIDTH-1:0]   opnd_c, madd_c, ovf_vec_c;
   ext_t                   sum_c, diff_c;
   logic                   is_sbc_c;

`ifdef DECIMAL_MODE_EN
   localparam int unsigned NIBBLES = REG_WIDTH / 4;

   // Nibble-serial BCD add with carry in/out
   function automatic ext_t bcd_add(input logic [REG_WIDTH-1:0] a,
                                    input logic [REG_WIDTH-1:0] b,
                                    input logic                 cin);
      logic [REG_WIDTH-1:0] r;
      logic                 c;
      logic [4:0]           s;
      r = '0;
      c = cin;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         s = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(c);
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[i*4 +: 4] = s[3:0];
      end
      return {c, r};
   endfunction

   // Nibble-serial BCD subtract; cin=1 means no incoming borrow
   function automatic ext_t bcd_sub(input logic [REG_WIDTH-1:0] a,
                                    input logic [REG_WIDTH-1:0] b,
                                    input logic                 cin);
      logic [REG_WIDTH-1:0] r;
      logic                 bw;
      logic [4:0]           d;
      r  = '0;
      bw = ~cin;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         d = 5'(a[i*4 +: 4]) - 5'(b[i*4 +: 4]) - 5'(bw);
         if (d[4]) begin
            d  = d - 5'd6;
            bw = 1'b1;
         end else begin
            bw = 1'b0;
         end
         r[i*4 +: 4] = d[3:0];
      end
      return {~bw, r};
   endfunction

   ext_t bcd_c;
`endif

   // State and output registers
   always_ff @(posedge phi1) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         aaa_q       <= 3'b000;
         imm_q       <= '0;
         is_imm_q    <= 1'b0;
         ill_q       <= 1'b0;
         acc_q       <= '0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= instruction_ready;
         aaa_q       <= aaa_d;
         imm_q       <= imm_d;
         is_imm_q    <= is_imm_d;
         ill_q       <= ill_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         v_q         <= v_d;
         z_q         <= z_d;
         c_q         <= c_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
      end
   end

   // Arithmetic datapath; SBC reuses the adder with the operand inverted
   always_comb begin
      opnd_c    = is_imm_q ? imm_q : mem_rdata;
      is_sbc_c  = (aaa_q == OP_SBC);
      madd_c    = is_sbc_c ? ~opnd_c : opnd_c;
      sum_c     = ext_t'(acc_q) + ext_t'(madd_c) + ext_t'(c_q);
      diff_c    = ext_t'(acc_q) - ext_t'(opnd_c);
      ovf_vec_c = ~(acc_q ^ madd_c) & (acc_q ^ sum_c[MSB:0]);
`ifdef DECIMAL_MODE_EN
      bcd_c     = is_sbc_c ? bcd_sub(acc_q, opnd_c, c_q) : bcd_add(acc_q, opnd_c, c_q);
`endif
   end

   // Only a low-to-high transition of ready starts an instruction
   assign capture_c = instruction_ready && !rdy_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      aaa_d       = aaa_q;
      imm_d       = imm_q;
      is_imm_d    = is_imm_q;
      ill_d       = ill_q;
      acc_d       = acc_q;
      n_d         = n_q;
      v_d         = v_q;
      z_d         = z_q;
      c_d         = c_q;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      done_d      = 1'b0;
      illegal_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (capture_c) begin
               aaa_d    = opcode[7:5];
               imm_d    = imm;
               is_imm_d = (opcode[4:2] == 3'b010);
               ill_d    = 1'b0;
               if ((opcode[1:0] != 2'b01) || (opcode == 8'h89)) begin
                  ill_d   = 1'b1;
                  state_d = DONE;
               end else if (opcode[7:5] == OP_STA) begin
                  // Strobes are registered, so they are launched on entry
                  state_d     = WRITE;
                  mem_wr_d    = 1'b1;
                  mem_addr_d  = addr;
                  mem_wdata_d = acc_q;
               end else if (opcode[4:2] == 3'b010) begin
                  state_d = EXEC;
               end else begin
                  state_d    = READ;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = addr;
               end
            end
         end
         READ:  state_d = EXEC;
         WRITE: state_d = DONE;
         EXEC: begin
            state_d = DONE;
            case (aaa_q)
               OP_ORA, OP_AND, OP_EOR, OP_LDA: begin
                  case (aaa_q)
                     OP_ORA:  acc_d = acc_q | opnd_c;
                     OP_AND:  acc_d = acc_q & opnd_c;
                     OP_EOR:  acc_d = acc_q ^ opnd_c;
                     default: acc_d = opnd_c;
                  endcase
                  n_d = acc_d[MSB];
                  z_d = (acc_d == '0);
               end
               OP_ADC, OP_SBC: begin
                  acc_d = sum_c[MSB:0];
                  c_d   = sum_c[REG_WIDTH];
                  v_d   = ovf_vec_c[MSB];
                  n_d   = sum_c[MSB];
                  z_d   = (sum_c[MSB:0] == '0);
`ifdef DECIMAL_MODE_EN
                  // Decimal mode adjusts acc and C; N,V,Z stay binary
                  if (d_flag) begin
                     acc_d = bcd_c[MSB:0];
                     c_d   = bcd_c[REG_WIDTH];
                  end
`endif
               end
               OP_CMP: begin
                  c_d = ~diff_c[REG_WIDTH];
                  n_d = diff_c[MSB];
                  z_d = (diff_c[MSB:0] == '0);
               end
               default: ;
            endcase
         end
         DONE: begin
            state_d   = IDLE;
            done_d    = 1'b1;
            illegal_d = ill_q;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign mem_rd           = mem_rd_q;
   assign mem_wr           = mem_wr_q;
   assign acc              = acc_q;
   assign status           = {n_q, v_q, 1'b1, 1'b0, d_flag, 1'b0, z_q, c_q};
   assign instruction_done = done_q;
   assign busy             = (state_q != IDLE);
   assign illegal          = illegal_q;

endmodule

// File: tb/tb_alu_executor.sv
// -----------------------------------------------------------------------------
// tb_alu_executor
// Directed-vector bench with a scoreboard: each issued instruction queues its
// expected completion (acc, status, illegal, cycle) and memory request; a
// monitor on the falling edge pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_alu_executor;

   logic        phi1 = 1'b0;
   logic        reset_n;
   logic        instruction_ready;
   logic [7:0]  opcode;
   logic [15:0] addr;
   logic [7:0]  imm;
   logic        d_flag;
   logic [7:0]  mem_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  acc;
   logic [7:0]  status;
   logic        instruction_done;
   logic        busy;
   logic        illegal;

   alu_executor #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .phi1              (phi1),
      .reset_n           (reset_n),
      .instruction_ready (instruction_ready),
      .opcode            (opcode),
      .addr              (addr),
      .imm               (imm),
      .d_flag            (d_flag),
      .mem_rdata         (mem_rdata),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_rd            (mem_rd),
      .mem_wr            (mem_wr),
      .acc               (acc),
      .status            (status),
      .instruction_done  (instruction_done),
      .busy              (busy),
      .illegal           (illegal)
   );

   always #5 phi1 = ~phi1;

   int cyc = 0;
   always @(posedge phi1) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] acc;
      logic [7:0] st;
      logic       ill;
      int         cyc;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [15:0] a;
      logic [7:0]  d;
      int          cyc;
   } mem_t;

   exp_t exp_q[$];
   mem_t mem_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got event expected none (t=%0t)", name, $time);
   endtask

   // Monitor: compares every completion and memory strobe against the queues
   always @(negedge phi1) begin
      if (mon_en) begin
         exp_t e;
         mem_t m;
         if (mem_rd && mem_wr) flag_fail("mem_rd_wr_overlap");
         if (mem_rd || mem_wr) begin
            if (mem_q.size() == 0) begin
               flag_fail("mem_unexpected");
            end else begin
               m = mem_q.pop_front();
               chk("mem_kind", 32'(mem_wr), 32'(m.wr));
               chk("mem_addr", 32'(mem_addr), 32'(m.a));
               if (m.wr) chk("mem_wdata", 32'(mem_wdata), 32'(m.d));
               chk("mem_cycle", 32'(cyc), 32'(m.cyc));
            end
         end
         if (instruction_done) begin
            if (exp_q.size() == 0) begin
               flag_fail("done_unexpected");
            end else begin
               e = exp_q.pop_front();
               chk("acc", 32'(acc), 32'(e.acc));
               chk("status", 32'(status), 32'(e.st));
               chk("illegal", 32'(illegal), 32'(e.ill));
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (illegal) begin
            flag_fail("illegal_without_done");
         end
      end
   end

   task automatic wait_drain();
      int k = 0;
      while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 20) begin
         @(negedge phi1);
         #1;
         k++;
      end
      if (exp_q.size() != 0 || mem_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: got %0d/%0d pending expected 0/0", exp_q.size(), mem_q.size());
         exp_q.delete();
         mem_q.delete();
      end
      @(negedge phi1);
   endtask

   // mk: 0 no memory access, 1 read, 2 write; hold: cycles ready stays high
   task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [7:0] im,
                        input logic [7:0] rd, input logic [7:0] eacc, input logic [7:0] est,
                        input logic eill, input int lat, input int mk, input int hold);
      exp_t e;
      mem_t m;
      int   c0;
      @(negedge phi1);
      opcode            = op;
      addr              = a;
      imm               = im;
      mem_rdata         = rd;
      instruction_ready = 1'b1;
      c0                = cyc;
      e.acc = eacc;
      e.st  = est;
      e.ill = eill;
      e.cyc = c0 + 1 + lat;
      exp_q.push_back(e);
      if (mk != 0) begin
         m.wr  = (mk == 2);
         m.a   = a;
         m.d   = eacc;
         m.cyc = c0 + 1;
         mem_q.push_back(m);
      end
      repeat (hold) @(negedge phi1);
      instruction_ready = 1'b0;
      wait_drain();
   endtask

   initial begin
      mem_t m;
      reset_n           = 1'b0;
      instruction_ready = 1'b0;
      d_flag            = 1'b0;
      opcode            = 8'h00;
      addr              = 16'h0000;
      imm               = 8'h00;
      mem_rdata         = 8'h00;
      repeat (3) @(negedge phi1);

      // Reset state
      chk("rst_acc", 32'(acc), 32'h00);
      chk("rst_status", 32'(status), 32'h20);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(instruction_done), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_mem_strobes", 32'({mem_rd, mem_wr}), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge phi1);

      //     op     addr      imm    rdata  acc    status ill lat mk hold
      issue(8'hA9, 16'h0000, 8'h80, 8'h00, 8'h80, 8'hA0, 0, 2, 0, 1); // LDA #$80
      issue(8'hA9, 16'h0000, 8'h50, 8'h00, 8'h50, 8'h20, 0, 2, 0, 1); // LDA #$50
      issue(8'h69, 16'h0000, 8'h50, 8'h00, 8'hA0, 8'hE0, 0, 2, 0, 1); // ADC #$50 overflow
      issue(8'hA9, 16'h0000, 8'h42, 8'h00, 8'h42, 8'h60, 0, 2, 0, 1); // LDA #$42
      issue(8'h8D, 16'h0200, 8'h00, 8'h00, 8'h42, 8'h60, 0, 2, 2, 1); // STA $0200
      issue(8'hA9, 16'h0000, 8'h10, 8'h00, 8'h10, 8'h60, 0, 2, 0, 1); // LDA #$10
      issue(8'hC5, 16'h0030, 8'h00, 8'h10, 8'h10, 8'h63, 0, 3, 1, 1); // CMP $30 equal
      issue(8'h02, 16'h0000, 8'h00, 8'h00, 8'h10, 8'h63, 1, 1, 0, 6); // illegal, ready held
      issue(8'h05, 16'h0044, 8'h00, 8'h0F, 8'h1F, 8'h61, 0, 3, 1, 1); // ORA $44
      issue(8'h29, 16'h0000, 8'hF0, 8'h00, 8'h10, 8'h61, 0, 2, 0, 1); // AND #$F0
      issue(8'h49, 16'h0000, 8'h10, 8'h00, 8'h00, 8'h63, 0, 2, 0, 1); // EOR #$10 -> zero
      issue(8'hE9, 16'h0000, 8'h01, 8'h00, 8'hFF, 8'hA0, 0, 2, 0, 1); // SBC #$01 borrow
      issue(8'h69, 16'h0000, 8'h01, 8'h00, 8'h00, 8'h23, 0, 2, 0, 1); // ADC #$01 wrap
      issue(8'hC9, 16'h0000, 8'h01, 8'h00, 8'h00, 8'hA0, 0, 2, 0, 1); // CMP #$01 less
      issue(8'hAD, 16'h1234, 8'h00, 8'h7F, 8'h7F, 8'h20, 0, 3, 1, 1); // LDA $1234
      issue(8'hE9, 16'h0000, 8'h80, 8'h00, 8'hFE, 8'hE0, 0, 2, 0, 1); // SBC #$80 overflow
      issue(8'h89, 16'h0000, 8'h00, 8'h00, 8'hFE, 8'hE0, 1, 1, 0, 1); // STA # is illegal

      // Reset while the memory read is outstanding: no completion may follow
      @(negedge phi1);
      opcode            = 8'hA5;
      addr              = 16'h0010;
      mem_rdata         = 8'h33;
      instruction_ready = 1'b1;
      m.wr  = 1'b0;
      m.a   = 16'h0010;
      m.d   = 8'h00;
      m.cyc = cyc + 1;
      mem_q.push_back(m);
      @(negedge phi1);
      instruction_ready = 1'b0;
      chk("abort_in_read", 32'(busy), 32'h1);
      reset_n = 1'b0;
      @(negedge phi1);
      reset_n = 1'b1;
      repeat (5) @(negedge phi1);
      chk("abort_acc", 32'(acc), 32'h00);
      chk("abort_status", 32'(status), 32'h20);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_mem_pending", 32'(mem_q.size()), 32'h0);

      // Decimal flag: BCD-adjusted acc when compiled in, binary otherwise
      d_flag = 1'b1;
      issue(8'hA9, 16'h0000, 8'h09, 8'h00, 8'h09, 8'h28, 0, 2, 0, 1); // LDA #$09
`ifdef DECIMAL_MODE_EN
      issue(8'h69, 16'h0000, 8'h01, 8'h00, 8'h10, 8'h28, 0, 2, 0, 1); // ADC #$01 -> 10
`else
      issue(8'h69, 16'h0000, 8'h01, 8'h00, 8'h0A, 8'h28, 0, 2, 0, 1); // ADC #$01 -> 0A
`endif
      issue(8'hE9, 16'h0000, 8'h01, 8'h00, 8'h08, 8'h29, 0, 2, 0, 1); // SBC #$01 C=0
      d_flag = 1'b0;

      repeat (4) @(negedge phi1);
      chk("end_done_pending", 32'(exp_q.size()), 32'h0);
      chk("end_mem_pending", 32'(mem_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
